// File: rtl/binary_mul_4_1_uni.sv
// binary_mul_4_1_uni
// Unsigned 4x4 multiplier with a single registered output stage.
// The product comes from an AND-gate partial-product array that is reduced
// by three ripple rows of half/full adders. It is captured into P when en=1.
//
// Ports:
//   clk    in   1  system clock, rising-edge active
//   rst_n  in   1  asynchronous reset, active-HIGH (1 = reset), clears P
//   en     in   1  capture enable
//   A      in   4  unsigned multiplicand
//   B      in   4  unsigned multiplier
//   P      out  8  registered product A*B
module binary_mul_4_1_uni (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P
);

  // Full adder cell: returns {carry, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    fa = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // One adder row: a half adder in bit 0, then three full adders.
  // Returns the 5-bit result, with the row carry-out in bit 4.
  function automatic logic [4:0] row_add(input logic [3:0] x, input logic [3:0] y);
    logic [4:0] r;
    logic [1:0] s;
    logic       c;
    r    = '0;
    r[0] = x[0] ^ y[0];
    c    = x[0] & y[0];
    for (int k = 1; k < 4; k++) begin
      s    = fa(x[k], y[k], c);
      r[k] = s[0];
      c    = s[1];
    end
    r[4] = c;
    row_add = r;
  endfunction

  logic [3:0] pp0, pp1, pp2, pp3;
  logic [4:0] r1, r2, r3;
  logic [7:0] prod;
  logic [7:0] p_d, p_q;

  always_comb begin
    pp0 = A & {4{B[0]}};
    pp1 = A & {4{B[1]}};
    pp2 = A & {4{B[2]}};
    pp3 = A & {4{B[3]}};
    // Each row retires its LSB as a product bit.
    // It passes the remaining four bits up to be aligned with the next partial product.
    r1   = row_add({1'b0, pp0[3:1]}, pp1);
    r2   = row_add(r1[4:1], pp2);
    r3   = row_add(r2[4:1], pp3);
    prod = {r3, r2[0], r1[0], pp0[0]};
  end

  always_comb begin
    p_d = p_q;
    if (en) p_d = prod;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) p_q <= 8'h00;
    else       p_q <= p_d;
  end

  assign P = p_q;

endmodule

// File: tb/tb_binary_mul_4_1_uni.sv
module tb_binary_mul_4_1_uni;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] A, B;
  logic [7:0] P;

  int tests  = 0;
  int failed = 0;
  logic [7:0] exp_q[$];

  binary_mul_4_1_uni dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .A    (A),
    .B    (B),
    .P    (P)
  );

  always #5 clk = ~clk;

  // Monitor: every enabled edge outside reset yields one product to check.
  initial begin
    logic e, r;
    logic [7:0] x;
    forever begin
      @(posedge clk);
      e = en;
      r = rst_n;
      #1;
      if (e === 1'b1 && r === 1'b0) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL capture_unexpected: P=%0d with no expected value queued", P);
        end else begin
          x = exp_q.pop_front();
          if (P !== x) begin
            failed++;
            $display("FAIL capture: P=%0d expected %0d", P, x);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] want);
    tests++;
    if (P !== want) begin
      failed++;
      $display("FAIL %s: P=%0d expected %0d", name, P, want);
    end
  endtask

  task automatic cap(input logic [3:0] a, input logic [3:0] b, input logic [7:0] want);
    @(negedge clk);
    A  = a;
    B  = b;
    en = 1'b1;
    exp_q.push_back(want);
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0;
  endtask

  // Directed vectors {A, B, hand-computed product}
  localparam int NV = 14;
  logic [15:0] vec [NV] = '{
    {4'd3,  4'd5,  8'd15},  {4'd7,  4'd9,  8'd63},  {4'd15, 4'd15, 8'd225},
    {4'd8,  4'd8,  8'd64},  {4'd0,  4'd13, 8'd0},   {4'd13, 4'd0,  8'd0},
    {4'd1,  4'd1,  8'd1},   {4'd1,  4'd2,  8'd2},   {4'd1,  4'd4,  8'd4},
    {4'd1,  4'd8,  8'd8},   {4'd15, 4'd9,  8'd135}, {4'd12, 4'd11, 8'd132},
    {4'd10, 4'd5,  8'd50},  {4'd14, 4'd13, 8'd182}
  };

  initial begin
    logic [15:0] v;
    rst_n = 1'b1;
    en    = 1'b1;
    A     = 4'hF;
    B     = 4'hF;

    // Reset dominates en with the clock running.
    #1 check("reset_initial", 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", 8'h00);
    end
    // Release reset. The next edge captures 15*15.
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.push_back(8'd225);
    idle();

    // Directed table
    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      cap(v[15:12], v[11:8], v[7:0]);
    end
    idle();

    // Back-to-back, 1-cycle lag
    cap(4'd1, 4'd1, 8'd1);
    cap(4'd2, 4'd2, 8'd4);
    cap(4'd4, 4'd4, 8'd16);
    cap(4'd15, 4'd1, 8'd15);
    idle();

    // Enable hold
    cap(4'd6, 4'd7, 8'd42);
    @(negedge clk);
    en = 1'b0;
    A  = 4'hF;
    B  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("enable_hold", 8'd42);
    end
    cap(4'd15, 4'd15, 8'd225);
    idle();
    check("pre_async_reset", 8'd225);

    // Async reset between edges clears P before the next edge.
    #2 rst_n = 1'b1;
    #1 check("async_reset", 8'h00);
    @(negedge clk);
    check("async_reset_held", 8'h00);
    rst_n = 1'b0;
    cap(4'd2, 4'd3, 8'd6);
    idle();

    // Exhaustive sweep, with the bench model as the reference
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        cap(4'(a), 4'(b), 8'(a * b));
    idle();
    idle();

    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL queue_drain: %0d expected values left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
